// File: rtl/clken_multi_div.sv
// Multi-channel clock-enable generator: per-channel divisor and mode
// (periodic, one-shot, cascade), one-cycle registered enable pulses.
module clken_multi_div #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 32,
    parameter int DEFAULT_DIV = 100000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] run,
    input  logic              sync_all,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [1:0]        cfg_mode,
    output logic [NUM_CH-1:0] clk_en,
    output logic [NUM_CH-1:0] busy
);

    localparam logic [1:0] MODE_ONE  = 2'b01;
    localparam logic [1:0] MODE_CASC = 2'b10;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DIV_W-1:0] cnt_reg;
            logic [DIV_W-1:0] div_reg;
            logic [1:0]       mode_reg;
            logic             done_reg;
            logic             run_prev_reg;
            logic             en_reg;
            logic             busy_reg;

            logic [DIV_W-1:0] deff;
            logic             casc_src;
            logic             cfg_hit;
            logic             clear_hit;
            logic             run_rise;
            logic             one_shot;
            logic             cnt_evt;
            logic             term;
            logic             done_next;

            // Channel 0 has no upstream channel, so cascade degrades to periodic.
            if (gi == 0) begin : g_first
                assign casc_src = 1'b1;
            end else begin : g_chain
                assign casc_src = clk_en[gi-1];
            end

            always_comb begin
                deff      = (div_reg == '0) ? DIV_W'(1) : div_reg;
                cfg_hit   = cfg_we && (cfg_ch == 3'(gi));
                clear_hit = cfg_hit || sync_all;
                run_rise  = run[gi] && !run_prev_reg;
                one_shot  = (mode_reg == MODE_ONE);
                // A run rising edge re-arms a finished one-shot and counts on the same edge.
                cnt_evt   = run[gi]
                            && ((mode_reg == MODE_CASC) ? casc_src : 1'b1)
                            && !(one_shot && done_reg && !run_rise);
                term      = cnt_evt && (cnt_reg == deff - DIV_W'(1));
                if (clear_hit)
                    done_next = 1'b0;
                else if (term && one_shot)
                    done_next = 1'b1;
                else if (run_rise)
                    done_next = 1'b0;
                else
                    done_next = done_reg;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg      <= '0;
                    div_reg      <= DIV_W'(DEFAULT_DIV);
                    mode_reg     <= 2'b00;
                    done_reg     <= 1'b0;
                    run_prev_reg <= 1'b0;
                    en_reg       <= 1'b0;
                    busy_reg     <= 1'b0;
                end else begin
                    run_prev_reg <= run[gi];
                    done_reg     <= done_next;
                    busy_reg     <= run[gi] && !done_next;
                    if (cfg_hit) begin
                        div_reg  <= cfg_div;
                        mode_reg <= cfg_mode;
                    end
                    if (clear_hit) begin
                        cnt_reg <= '0;
                        en_reg  <= 1'b0;
                    end else if (cnt_evt) begin
                        if (term) begin
                            cnt_reg <= '0;
                            en_reg  <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + DIV_W'(1);
                            en_reg  <= 1'b0;
                        end
                    end else begin
                        en_reg <= 1'b0;
                    end
                end
            end

            assign clk_en[gi] = en_reg;
            assign busy[gi]   = busy_reg;
        end
    endgenerate

endmodule

// File: tb/tb_clken_multi_div.sv
// Directed bench for clken_multi_div with DEFAULT_DIV = 5 and four channels.
module tb_clken_multi_div;

    localparam int NCH = 4;
    localparam int DW  = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic [NCH-1:0] run;
    logic           sync_all;
    logic           cfg_we;
    logic [2:0]     cfg_ch;
    logic [DW-1:0]  cfg_div;
    logic [1:0]     cfg_mode;
    logic [NCH-1:0] clk_en;
    logic [NCH-1:0] busy;

    int total = 0;
    int bad   = 0;

    clken_multi_div #(.NUM_CH(NCH), .DIV_W(DW), .DEFAULT_DIV(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .sync_all (sync_all),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_mode (cfg_mode),
        .clk_en   (clk_en),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [2:0] ch, input logic [DW-1:0] dv, input logic [1:0] md);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_div  = dv;
        cfg_mode = md;
        tick();
        chk("cfg_edge_en", 8'(clk_en & (4'b0001 << ch)), 8'h00);
        cfg_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; run = '0; sync_all = 1'b0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = '0;
        tick(); tick();
        chk("reset_en", 8'(clk_en), 8'h00);
        chk("reset_busy", 8'(busy), 8'h00);

        // Periodic at default divisor 5 on channel 0.
        reset = 1'b0; run = 4'b0001;
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk("per_en", 8'(clk_en), (k % 5 == 0) ? 8'h01 : 8'h00);
            chk("per_busy", 8'(busy), 8'h01);
        end
        $display("phase periodic done");

        // Pause: 2 counting edges, 10 paused, then 2 more -> pulse on 4th.
        cfg(3'd0, 32'd4, 2'b00);
        for (int k = 1; k <= 2; k++) begin
            tick();
            chk("pause_pre", 8'(clk_en), 8'h00);
        end
        run = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("pause_hold", 8'(clk_en), 8'h00);
        end
        chk("pause_busy", 8'(busy), 8'h00);
        run = 4'b0001;
        tick();
        chk("pause_post3", 8'(clk_en), 8'h00);
        tick();
        chk("pause_post4", 8'(clk_en), 8'h01);

        // div = 0 and div = 1 both give a pulse on every edge.
        cfg(3'd0, 32'd0, 2'b00);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("div0_en", 8'(clk_en), 8'h01);
        end
        cfg(3'd0, 32'd1, 2'b00);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("div1_en", 8'(clk_en), 8'h01);
        end
        $display("phase pause/edge divisors done");

        // One-shot on channel 1, div 3.
        run = 4'b0010;
        cfg(3'd1, 32'd3, 2'b01);
        chk("os_busy_start", 8'(busy), 8'h02);
        for (int k = 1; k <= 23; k++) begin
            tick();
            chk("os_en", 8'(clk_en), (k == 3) ? 8'h02 : 8'h00);
            if (k >= 3) chk("os_busy_done", 8'(busy), 8'h00);
        end
        run = 4'b0000;
        tick();
        chk("os_low", 8'(clk_en), 8'h00);
        run = 4'b0010;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("os_rearm", 8'(clk_en), (k == 3) ? 8'h02 : 8'h00);
        end
        $display("phase one-shot done");

        // Cascade: ch0 div 3 feeds ch1 div 4 -> ch1 every 12 cycles.
        run = 4'b0000;
        cfg(3'd0, 32'd3, 2'b00);
        cfg(3'd1, 32'd4, 2'b10);
        run = 4'b0011;
        for (int k = 1; k <= 26; k++) begin
            tick();
            chk("casc_ch0", 8'(clk_en[0]), (k % 3 == 0) ? 8'h01 : 8'h00);
            chk("casc_ch1", 8'(clk_en[1]), (k > 1 && (k - 1) % 12 == 0) ? 8'h01 : 8'h00);
        end
        $display("phase cascade done");

        // cfg write on the terminal-count cycle suppresses the pulse.
        run = 4'b0000;
        cfg(3'd0, 32'd3, 2'b00);
        run = 4'b0001;
        tick(); chk("coll_pre1", 8'(clk_en), 8'h00);
        tick(); chk("coll_pre2", 8'(clk_en), 8'h00);
        cfg(3'd0, 32'd2, 2'b00);
        chk("coll_suppress", 8'(clk_en), 8'h00);
        tick(); chk("coll_new1", 8'(clk_en), 8'h00);
        tick(); chk("coll_new2", 8'(clk_en), 8'h01);

        // sync_all realigns: ch0 div 2, ch1 div 3, ch2/ch3 default 5.
        run = 4'b1111;
        cfg(3'd1, 32'd3, 2'b00);
        for (int k = 1; k <= 4; k++) tick();
        sync_all = 1'b1;
        tick();
        chk("sync_edge", 8'(clk_en), 8'h00);
        sync_all = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            logic [3:0] e;
            // An out-of-range channel write lands on edge 3 and must change nothing.
            if (k == 3) begin
                cfg_we = 1'b1; cfg_ch = 3'd5; cfg_div = 32'd7; cfg_mode = 2'b01;
            end
            e = {(k % 5 == 0), (k % 5 == 0), (k % 3 == 0), (k % 2 == 0)};
            tick();
            cfg_we = 1'b0;
            chk("sync_align", 8'(clk_en), 8'(e));
            chk("sync_busy", 8'(busy), 8'h0f);
        end
        $display("phase collisions done");

        // Reset mid-count on ch2 (counter 7 of div 10).
        run = 4'b0000;
        cfg(3'd2, 32'd10, 2'b00);
        run = 4'b0100;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("rst_pre", 8'(clk_en), 8'h00);
        end
        reset = 1'b1;
        tick();
        chk("rst_en", 8'(clk_en), 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("rst_post", 8'(clk_en), (k % 5 == 0) ? 8'h04 : 8'h00);
        end
        $display("phase reset done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clken_multi_div.md
Name: clken_multi_div

Overview:
- Multi-channel, runtime-programmable clock-enable generator.
- Produces NUM_CH independent single-cycle enable pulses from one system clock. Each channel has its own divisor and mode: periodic, one-shot or cascaded.
- Generalises the fixed 1 Hz enable generator. Timebase for displays, debouncers, timers and blink logic on the 100 MHz board clock.

Parameters:
- NUM_CH, 4, number of independent enable channels (1..8).
- DIV_W, 32, width of each divisor register and counter.
- DEFAULT_DIV, 100000000, divisor loaded into every channel at reset (1 Hz at 100 MHz).

Ports:
- clk  input  1  system clock (100 MHz on board).
- reset  input  1  synchronous, active-high reset.
- run  input  NUM_CH  per-channel count enable; low = pause.
- sync_all  input  1  one-cycle strobe; realigns all channels.
- cfg_we  input  1  configuration write strobe.
- cfg_ch  input  3  channel index for the write; values >= NUM_CH are ignored.
- cfg_div  input  DIV_W  new divisor for the write.
- cfg_mode  input  2  new mode: 00 periodic, 01 one-shot, 10 cascade, 11 reserved (treated as periodic).
- clk_en  output  NUM_CH  registered one-cycle enable pulses.
- busy  output  NUM_CH  channel is actively counting toward a pulse.

Behaviour:
- Reset, sampled on the rising clk edge, sets every channel as follows:
  - counter = 0, div = DEFAULT_DIV, mode = periodic, done = 0;
  - clk_en = 0, busy = 0.
- Effective divisor Deff = max(div, 1). div = 0 behaves exactly as div = 1.
- Counting event per channel:
  - periodic / one-shot: every edge with run[i] = 1;
  - cascade: every edge with run[i] = 1 and clk_en[i-1] = 1 (registered value);
  - channel 0 in cascade behaves as periodic.
- On a counting event:
  - if counter == Deff-1: counter <= 0, clk_en[i] <= 1;
  - else: counter <= counter+1, clk_en[i] <= 0.
- With no counting event, clk_en[i] <= 0 and the counter holds. run low is a pause, not a clear.
- Timing: with run held high from the first edge after reset, clk_en[i] is high for exactly one cycle after edges Deff, 2·Deff, 3·Deff, … Deff = 1 gives clk_en constantly high.
- One-shot mode:
  - the first pulse sets done[i]; no further counting events while done = 1;
  - done clears on a rising edge of run[i] (registered previous value), on a cfg write to that channel, or on sync_all.
- busy[i] = run[i] & ~done[i], registered. In cascade mode busy also requires Deff > 0 (always true).
- cfg write (cfg_we = 1, cfg_ch < NUM_CH):
  - div and mode of that channel update, its counter and done are cleared, and its clk_en is 0 on the following cycle;
  - a write coinciding with a terminal count wins, so no pulse is emitted;
  - other channels are unaffected.
- sync_all clears every counter and done flag and forces all clk_en to 0 next cycle. Divisors and modes are kept.
- Priority: reset > (cfg write, sync_all) > counting. cfg write and sync_all in the same cycle are both applied.
- Reset mid-count discards progress; the new divisor reverts to DEFAULT_DIV.
- Cascade latency: a channel-i pulse occurs one cycle after the channel-(i-1) pulse that completes its count. Total period = product of Deff along the chain, expressed in base-clock cycles.
- Counter width DIV_W; no overflow, since counter < Deff <= 2^DIV_W-1.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Periodic timing: DEFAULT_DIV = 5, NUM_CH = 4, release reset, run = 4'b0001 -> clk_en[0] high for one cycle after edges 5, 10, 15; clk_en[3:1] = 0; busy = 4'b0001.
- Pause and edge divisors: div = 4 on ch0; run[0] high 2 edges, low 10 edges, high again -> first pulse after 4 total counting edges, none during pause. Then div = 0 and div = 1 -> clk_en[0] high every cycle.
- One-shot: cfg ch1 div = 3 mode = 01, run[1] held high -> exactly one pulse after edge 3, busy[1] falls, no pulse over 20 more cycles. Toggle run[1] low then high -> one further pulse 3 counting edges later.
- Cascade: ch0 div = 3 periodic, ch1 div = 4 cascade, run = 4'b0011 -> clk_en[1] every 12 cycles, always one cycle after a clk_en[0] pulse.
- Collisions: cfg write to ch0 on its terminal-count cycle -> no pulse, counter restarts with the new div. sync_all mid-count on all channels -> all clk_en 0, next pulses exactly Deff edges later and phase-aligned across channels. cfg_ch = 5 with NUM_CH = 4 -> no state change.
- Reset mid-operation: assert reset for one edge while ch2 has counter = 7, div = 10 -> clk_en = 0, busy = 0, div reverts to DEFAULT_DIV, first pulse DEFAULT_DIV edges after release.
